// File: rtl/tank_pkg.sv
// Shared bullet/tank types: bullet_t slot layout, dir_e turret directions,
// dir_to_delta() unit-step lookup and the exclusive screen bounds H_MAX/V_MAX.
package tank_pkg;

  localparam int H_MAX = 640;
  localparam int V_MAX = 480;

  typedef enum logic [2:0] {
    DIR_U  = 3'd0,
    DIR_UR = 3'd1,
    DIR_R  = 3'd2,
    DIR_DR = 3'd3,
    DIR_D  = 3'd4,
    DIR_DL = 3'd5,
    DIR_L  = 3'd6,
    DIR_UL = 3'd7
  } dir_e;

  typedef struct packed {
    logic [2:0] rsvd;
    logic [9:0] y;
    logic [9:0] x;
    logic [4:0] life;
    dir_e       dir;
    logic       valid;
  } bullet_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } delta_t;

  // Screen y grows downward, so "up" is dy = -1.
  function automatic delta_t dir_to_delta(dir_e d);
    delta_t r;
    unique case (d)
      DIR_U:  r = '{dx: 2'sb00, dy: 2'sb11};
      DIR_UR: r = '{dx: 2'sb01, dy: 2'sb11};
      DIR_R:  r = '{dx: 2'sb01, dy: 2'sb00};
      DIR_DR: r = '{dx: 2'sb01, dy: 2'sb01};
      DIR_D:  r = '{dx: 2'sb00, dy: 2'sb01};
      DIR_DL: r = '{dx: 2'sb11, dy: 2'sb01};
      DIR_L:  r = '{dx: 2'sb11, dy: 2'sb00};
      DIR_UL: r = '{dx: 2'sb11, dy: 2'sb11};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bullet_step.sv
// One-frame bullet update: cur -> nxt (move, age, retire or bounce).
// Macro BULLET_BOUNCE_EN: screen edges reflect instead of killing.
module bullet_step
  import tank_pkg::*;
#(
  parameter int SPEED = 4
) (
  input  bullet_t cur,
  output bullet_t nxt
);

  localparam logic [10:0] SPD = 11'(SPEED);

  delta_t      d;
  logic [10:0] sx;
  logic [10:0] sy;
  logic [10:0] nx;
  logic [10:0] ny;
  logic        x_lo;
  logic        x_hi;
  logic        y_lo;
  logic        y_hi;
  logic        dead;
  logic        kill;
  logic [2:0]  fd;

  always_comb begin
    d  = dir_to_delta(cur.dir);
    sx = (d.dx == 2'sb01) ? SPD :
         (d.dx == 2'sb11) ? -SPD : '0;
    sy = (d.dy == 2'sb01) ? SPD :
         (d.dy == 2'sb11) ? -SPD : '0;
    // 11-bit two's complement; bit 10 flags a move past 0.
    nx   = {1'b0, cur.x} + sx;
    ny   = {1'b0, cur.y} + sy;
    x_lo = nx[10];
    x_hi = !nx[10] && (nx[9:0] >= 10'(H_MAX));
    y_lo = ny[10];
    y_hi = !ny[10] && (ny[9:0] >= 10'(V_MAX));
    dead = cur.life <= 5'd1;
    fd   = cur.dir;
    kill = 1'b0;
    nxt  = cur;
    if (cur.valid) begin
      nxt.life = cur.life - 5'd1;
      nxt.x    = nx[9:0];
      nxt.y    = ny[9:0];
`ifdef BULLET_BOUNCE_EN
      if (x_lo) nxt.x = '0;
      if (x_hi) nxt.x = 10'(H_MAX - 1);
      if (y_lo) nxt.y = '0;
      if (y_hi) nxt.y = 10'(V_MAX - 1);
      // 8-d mirrors dx, 4-d mirrors dy (mod 8).
      if (x_lo || x_hi) fd = 3'd0 - fd;
      if (y_lo || y_hi) fd = 3'd4 - fd;
      nxt.dir = dir_e'(fd);
      kill    = dead;
`else
      kill = dead | x_lo | x_hi | y_lo | y_hi;
`endif
      if (kill) nxt = '0;
    end
  end

endmodule

// File: rtl/bullet_engine.sv
// Bullet table for all tanks: fire edge detect, cooldown, spawn, vblank sweep.
// Ports: CLK/Reset_n, frame_tick, clear_all, fire, tank pose -> bullet_array, busy.
module bullet_engine
  import tank_pkg::*;
#(
  parameter int TANK_NUM        = 2,
  parameter int ARRAY_SIZE      = 8,
  parameter int SPEED           = 4,
  parameter int LIFETIME        = 20,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SPAWN_OFS       = 16
) (
  input  logic                                     CLK,
  input  logic                                     Reset_n,
  input  logic                                     frame_tick,
  input  logic                                     clear_all,
  input  logic [TANK_NUM-1:0]                      fire,
  input  logic [TANK_NUM-1:0][9:0]                 tank_x,
  input  logic [TANK_NUM-1:0][9:0]                 tank_y,
  input  logic [TANK_NUM-1:0][2:0]                 turret_dir,
  output logic [TANK_NUM-1:0][ARRAY_SIZE-1:0][31:0] bullet_array,
  output logic                                     busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_SPAWN = 2'd2;
  localparam int         KW      = $clog2(ARRAY_SIZE);

  logic [1:0]                         state;
  logic [KW-1:0]                      k;
  logic                               open_st;
  logic [TANK_NUM-1:0]                fire_q;
  logic [TANK_NUM-1:0]                pending;
  logic [TANK_NUM-1:0]                rise;
  logic [TANK_NUM-1:0]                hit;
  logic [TANK_NUM-1:0]                take;
  logic [TANK_NUM-1:0][7:0]           cool;
  logic [TANK_NUM-1:0][KW-1:0]        slot;
  bullet_t [TANK_NUM-1:0][ARRAY_SIZE-1:0] tbl;
  bullet_t [TANK_NUM-1:0]             step_in;
  bullet_t [TANK_NUM-1:0]             step_out;
  bullet_t [TANK_NUM-1:0]             fresh;

  assign bullet_array = tbl;
  assign busy         = state == S_SWEEP;
  assign open_st      = (state == S_IDLE) || (state == S_SPAWN);

  always_comb begin
    rise = fire & ~fire_q;
    for (int t = 0; t < TANK_NUM; t++) begin
      hit[t]  = 1'b0;
      slot[t] = '0;
      for (int s = ARRAY_SIZE - 1; s >= 0; s--) begin
        if (!tbl[t][s].valid) begin
          hit[t]  = 1'b1;
          slot[t] = KW'(s);
        end
      end
      take[t] = open_st && pending[t] &&
                (cool[t] == 8'd0) && hit[t];
      step_in[t] = tbl[t][k];
      fresh[t]   = '{rsvd:  3'd0,
                     y:     tank_y[t] + 10'(SPAWN_OFS),
                     x:     tank_x[t] + 10'(SPAWN_OFS),
                     life:  5'(LIFETIME),
                     dir:   dir_e'(turret_dir[t]),
                     valid: 1'b1};
    end
  end

  for (genvar t = 0; t < TANK_NUM; t++) begin : g_step
    bullet_step #(
      .SPEED(SPEED)
    ) u_step (
      .cur(step_in[t]),
      .nxt(step_out[t])
    );
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      k       <= '0;
      fire_q  <= '0;
      pending <= '0;
      cool    <= '0;
      tbl     <= '0;
    end else begin
      fire_q <= fire;
      // A request seen in IDLE/SPAWN is consumed: spawned or dropped.
      for (int t = 0; t < TANK_NUM; t++) begin
        if (open_st && pending[t]) pending[t] <= 1'b0;
        if (rise[t]) pending[t] <= 1'b1;
      end
      if (clear_all) begin
        state <= S_IDLE;
        k     <= '0;
        cool  <= '0;
        tbl   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (frame_tick) begin
              state <= S_SWEEP;
              k     <= '0;
              for (int t = 0; t < TANK_NUM; t++)
                if (cool[t] != 8'd0) cool[t] <= cool[t] - 8'd1;
            end
          end
          S_SWEEP: begin
            for (int t = 0; t < TANK_NUM; t++)
              tbl[t][k] <= step_out[t];
            k <= k + 1'b1;
            if (k == KW'(ARRAY_SIZE - 1)) state <= S_SPAWN;
          end
          S_SPAWN: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
        for (int t = 0; t < TANK_NUM; t++) begin
          if (take[t]) begin
            tbl[t][slot[t]] <= fresh[t];
            cool[t]         <= 8'(COOLDOWN_FRAMES);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bullet_engine.sv
// Self-checking bench for bullet_engine: vector table plus corner sequences.
// A second instance runs with COOLDOWN_FRAMES=0 for the table-full case.
module tb_bullet_engine;
  import tank_pkg::*;

  typedef struct {
    int tx; int ty; int dir; int nsw;
    int ev; int ex; int ey; int ed; int el;
  } vec_t;

  localparam int NV = 12;

  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_tick = 1'b0;
  logic clear_all = 1'b0;
  logic [1:0] fire = '0;
  logic [1:0] fire_nc = '0;
  logic [1:0][9:0] tank_x = '0;
  logic [1:0][9:0] tank_y = '0;
  logic [1:0][2:0] turret_dir = '0;
  logic [1:0][7:0][31:0] arr;
  logic [1:0][7:0][31:0] arr_nc;
  logic busy;
  logic busy_nc;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[NV];

  always #5 CLK = ~CLK;

  bullet_engine dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .frame_tick(frame_tick), .clear_all(clear_all),
    .fire(fire), .tank_x(tank_x), .tank_y(tank_y),
    .turret_dir(turret_dir),
    .bullet_array(arr), .busy(busy)
  );

  bullet_engine #(.COOLDOWN_FRAMES(0)) dut_nc (
    .CLK(CLK), .Reset_n(Reset_n),
    .frame_tick(frame_tick), .clear_all(clear_all),
    .fire(fire_nc), .tank_x(tank_x), .tank_y(tank_y),
    .turret_dir(turret_dir),
    .bullet_array(arr_nc), .busy(busy_nc)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int v, input int x,
                                       input int y, input int d,
                                       input int l);
    if (v == 0) return 32'd0;
    return {3'b000, 10'(y), 10'(x), 5'(l), 3'(d), 1'b1};
  endfunction

  function automatic int nvalid(input logic [7:0][31:0] t);
    int n = 0;
    for (int s = 0; s < 8; s++) n += int'(t[s][0]);
    return n;
  endfunction

  task automatic frame();
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick(1);
    if (busy) chk("sweep_timeout", 32'(busy), 32'd0);
    tick(1);
  endtask

  task automatic shoot(input int t);
    fire[t] = 1'b1;
    tick(1);
    fire[t] = 1'b0;
    tick(2);
  endtask

  task automatic shoot_nc(input int t);
    fire_nc[t] = 1'b1;
    tick(1);
    fire_nc[t] = 1'b0;
    tick(2);
  endtask

  task automatic clr();
    clear_all = 1'b1;
    tick(1);
    clear_all = 1'b0;
    tick(1);
  endtask

  task automatic pose(input int x, input int y, input int d);
    tank_x[0] = 10'(x);
    tank_y[0] = 10'(y);
    turret_dir[0] = 3'(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{100, 200, 2, 1, 1, 120, 216, 2, 19};
    vecs[3]  = '{100,   0, 0, 4, 1, 116,   0, 0, 16};
    vecs[5]  = '{200, 448, 4, 3, 1, 216, 476, 4, 17};
    vecs[8]  = '{100, 200, 3, 2, 1, 124, 224, 3, 18};
    vecs[9]  = '{100, 200, 7, 1, 1, 112, 212, 7, 19};
    vecs[10] = '{100, 200, 5, 1, 1, 112, 220, 5, 19};
    vecs[11] = '{100, 200, 0, 2, 1, 116, 208, 0, 18};
`ifdef BULLET_BOUNCE_EN
    vecs[1]  = '{620, 200, 2, 1, 1, 639, 216, 6, 19};
    vecs[2]  = '{620, 100, 1, 1, 1, 639, 112, 7, 19};
    vecs[4]  = '{100,   0, 0, 5, 1, 116,   0, 4, 15};
    vecs[6]  = '{200, 448, 4, 4, 1, 216, 479, 0, 16};
    vecs[7]  = '{  0, 100, 6, 5, 1,   0, 116, 2, 15};
`else
    vecs[1]  = '{620, 200, 2, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{620, 100, 1, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{100,   0, 0, 5, 0, 0, 0, 0, 0};
    vecs[6]  = '{200, 448, 4, 4, 0, 0, 0, 0, 0};
    vecs[7]  = '{  0, 100, 6, 5, 0, 0, 0, 0, 0};
`endif

    // reset state, then idle frames
    tick(2);
    chk("rst_tbl", 32'(|arr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tbl_nc", 32'(|arr_nc), 32'd0);
    Reset_n = 1'b1;
    tick(2);
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    chk("busy_sweep", 32'(busy), 32'd1);
    tick(9);
    chk("busy_done", 32'(busy), 32'd0);
    frame();
    frame();
    chk("idle_tbl", 32'(|arr), 32'd0);

    // spawn + sweep vectors on slot [0][0]
    for (int i = 0; i < NV; i++) begin
      clr();
      pose(vecs[i].tx, vecs[i].ty, vecs[i].dir);
      exp_q.push_back(word(1, vecs[i].tx + 16, vecs[i].ty + 16,
                           vecs[i].dir, 20));
      exp_q.push_back(word(vecs[i].ev, vecs[i].ex, vecs[i].ey,
                           vecs[i].ed, vecs[i].el));
      shoot(0);
      chk($sformatf("v%0d_spawn", i), arr[0][0], exp_q.pop_front());
      repeat (vecs[i].nsw) frame();
      chk($sformatf("v%0d_step", i), arr[0][0], exp_q.pop_front());
    end

    // table full on tank1 with no cooldown
    clr();
    tank_y[1] = 10'd50;
    turret_dir[1] = 3'd4;
    for (int i = 0; i < 9; i++) begin
      tank_x[1] = 10'(i * 10);
      if (i < 8) exp_q.push_back(word(1, i * 10 + 16, 66, 4, 20));
      shoot_nc(1);
    end
    for (int s = 0; s < 8; s++)
      chk($sformatf("full_s%0d", s), arr_nc[1][s], exp_q.pop_front());
    chk("full_t0_empty", 32'(|arr_nc[0]), 32'd0);

    // cooldown boundary
    clr();
    pose(300, 200, 2);
    shoot(0);
    shoot(0);
    chk("cd_first", arr[0][0], word(1, 316, 216, 2, 20));
    chk("cd_drop0", arr[0][1], 32'd0);
    repeat (7) frame();
    shoot(0);
    chk("cd_drop7", arr[0][1], 32'd0);
    frame();
    shoot(0);
    chk("cd_ok8", arr[0][1], word(1, 316, 216, 2, 20));
    chk("cd_moved", arr[0][0], word(1, 348, 216, 2, 12));

    // fire held high for 50 frames: one bullet, then life expiry
    clr();
    pose(300, 200, 2);
    fire[0] = 1'b1;
    tick(3);
    chk("hold_one", 32'(nvalid(arr[0])), 32'd1);
    repeat (19) frame();
    chk("hold_life1", arr[0][0], word(1, 392, 216, 2, 1));
    repeat (2) frame();
    chk("hold_expired", 32'(nvalid(arr[0])), 32'd0);
    repeat (29) frame();
    chk("hold_no_more", 32'(nvalid(arr[0])), 32'd0);
    fire[0] = 1'b0;
    tick(1);

    // reset in the middle of a sweep
    clr();
    pose(100, 200, 2);
    shoot(0);
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    tick(4);
    Reset_n = 1'b0;
    #2;
    chk("midrst_busy", 32'(busy), 32'd0);
    tick(1);
    Reset_n = 1'b1;
    tick(2);
    chk("midrst_tbl", 32'(|arr), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // fire edge coincident with frame_tick spawns in SPAWN, unmoved
    fire[0] = 1'b1;
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    fire[0] = 1'b0;
    tick(2);
    chk("coinc_pending", arr[0][0], 32'd0);
    chk("coinc_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20 && busy; i++) tick(1);
    if (busy) chk("coinc_timeout", 32'(busy), 32'd0);
    tick(1);
    chk("coinc_spawn", arr[0][0], word(1, 116, 216, 2, 20));

    // clear_all aborts a sweep
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    tick(2);
    clear_all = 1'b1;
    tick(1);
    clear_all = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_tbl", 32'(|arr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
